// File: rtl/ram_dp_pkg.sv
// rtl/ram_dp_pkg.sv - shared types and read-latency constants for the clearable dual-port RAM (RAM_DP_OUT_REG_EN selects latency)
package ram_dp_pkg;

  // Control FSM states: normal operation or sequential array clear
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Read latency without and with the optional output register
  localparam int unsigned RD_LAT_DIRECT  = 1;
  localparam int unsigned RD_LAT_OUT_REG = 2;

`ifdef RAM_DP_OUT_REG_EN
  localparam int unsigned RD_LATENCY = RD_LAT_OUT_REG;
`else
  localparam int unsigned RD_LATENCY = RD_LAT_DIRECT;
`endif

endpackage

// File: rtl/ram_dp_clr_ctrl.sv
// rtl/ram_dp_clr_ctrl.sv - clear FSM and address counter that zeroes the array one word per cycle
module ram_dp_clr_ctrl
  import ram_dp_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ADDRESS = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_start_i,
  output logic [ADDRESS-1:0] clr_addr_o,
  output logic               clr_we_o,
  output logic               busy_o
);

  localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(DEPTH - 1);

  clr_state_e         state_q;
  logic [ADDRESS-1:0] cnt_q;
  logic               busy_q;

  // Reset lands in CLEAR at address 0 so the array is always scrubbed before use;
  // a clear request arriving while already clearing is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_start_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDRESS'(1);
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr_o = cnt_q;
  assign clr_we_o   = busy_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - byte-enabled dual-port RAM with whole-array clear and write-first bypass; RAM_DP_OUT_REG_EN adds an output register
module ram_dp_clr
  import ram_dp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int ADDRESS = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr_start,
  output logic                 clr_busy,
  input  logic                 wr_en,
  input  logic [ADDRESS-1:0]   wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd_en,
  input  logic [ADDRESS-1:0]   rd_addr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 rd_valid,
  output logic                 req_drop
);

  localparam int NBYTES = WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDRESS still compares correctly
  localparam logic [ADDRESS:0] DEPTH_W = (ADDRESS + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDRESS-1:0] clr_addr;
  logic               clr_we;
  logic               busy;

  logic               wr_in_range;
  logic               rd_in_range;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_oor;
  logic               ctl_drop_d;
  logic [WIDTH-1:0]   rd_data_d;

  logic               ctl_drop_q;
  logic               rd_valid_q1;
  logic               rd_drop_q1;
  logic [WIDTH-1:0]   rd_data_q1;

  ram_dp_clr_ctrl #(
    .DEPTH   (DEPTH),
    .ADDRESS (ADDRESS)
  ) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .clr_start_i (clr_start),
    .clr_addr_o  (clr_addr),
    .clr_we_o    (clr_we),
    .busy_o      (busy)
  );

  assign clr_busy    = busy;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_fire     = wr_en & ~busy & wr_in_range;
  assign rd_fire     = rd_en & ~busy;
  assign rd_oor      = rd_fire & ~rd_in_range;

  // Drops reported one cycle later: anything requested during a clear, and out-of-range writes.
  // Out-of-range reads travel with the read pipeline instead so they line up with rd_valid.
  assign ctl_drop_d = (busy & (wr_en | rd_en)) | (wr_en & ~busy & ~wr_in_range);

  // Read word with write-first merge: bytes being written this cycle come from data_in
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      rd_data_d = mem_q[rd_addr];
      if (wr_fire && (wr_addr == rd_addr)) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_be[b]) begin
            rd_data_d[8*b +: 8] = data_in[8*b +: 8];
          end
        end
      end
    end
  end

  // Storage array: the clear sequence owns the write port while busy; it is the only initialisation
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  // First read stage and drop flags; read data only moves when a read completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctl_drop_q  <= 1'b0;
      rd_valid_q1 <= 1'b0;
      rd_drop_q1  <= 1'b0;
      rd_data_q1  <= '0;
    end else begin
      ctl_drop_q  <= ctl_drop_d;
      rd_valid_q1 <= rd_fire;
      rd_drop_q1  <= rd_oor;
      if (rd_fire) begin
        rd_data_q1 <= rd_data_d;
      end
    end
  end

`ifdef RAM_DP_OUT_REG_EN
  logic               rd_valid_q2;
  logic               rd_drop_q2;
  logic [WIDTH-1:0]   rd_data_q2;

  // Output register stage: delays read data, valid and read-drop by one more cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q2 <= 1'b0;
      rd_drop_q2  <= 1'b0;
      rd_data_q2  <= '0;
    end else begin
      rd_valid_q2 <= rd_valid_q1;
      rd_drop_q2  <= rd_drop_q1;
      if (rd_valid_q1) begin
        rd_data_q2 <= rd_data_q1;
      end
    end
  end

  assign data_out = rd_data_q2;
  assign rd_valid = rd_valid_q2;
  assign req_drop = ctl_drop_q | rd_drop_q2;
`else
  assign data_out = rd_data_q1;
  assign rd_valid = rd_valid_q1;
  assign req_drop = ctl_drop_q | rd_drop_q1;
`endif

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 64, number of words (2 to 2^ADDRESS).
REQ-003 The block SHALL have parameter ADDRESS, default 6, address width in bits.
REQ-004 The block SHALL have port clock  input  1  rising-edge clock for all logic.
REQ-005 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port clr_start  input  1  one-cycle request to zero the whole array.
REQ-007 The block SHALL have port clr_busy  output  1  high while the array clear is in progress.
REQ-008 The block SHALL have port wr_en  input  1  write request.
REQ-009 The block SHALL have port wr_addr  input  ADDRESS  write address.
REQ-010 The block SHALL have port wr_be  input  WIDTH/8  byte enables; bit k enables data_in[8k+7:8k].
REQ-011 The block SHALL have port data_in  input  WIDTH  write data.
REQ-012 The block SHALL have port rd_en  input  1  read request.
REQ-013 The block SHALL have port rd_addr  input  ADDRESS  read address.
REQ-014 The block SHALL have port data_out  output  WIDTH  read data.
REQ-015 The block SHALL have port rd_valid  output  1  one-cycle pulse qualifying data_out.
REQ-016 The block SHALL have port req_drop  output  1  one-cycle pulse when a wr_en or rd_en is discarded.

Function
REQ-017 Control FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE one cycle after the word at address DEPTH-1 is zeroed.
REQ-018 In CLEAR, one word per cycle SHALL be zeroed, ascending from 0, so a clear takes exactly DEPTH cycles; clr_busy=1 for exactly those cycles.
REQ-019 clr_start while in CLEAR SHALL be ignored (no restart).
REQ-020 In CLEAR, wr_en and rd_en SHALL be discarded, rd_valid stays 0, and req_drop=1 the following cycle for each cycle with wr_en or rd_en high.
REQ-021 In IDLE, a write SHALL update only the bytes with wr_be bit set; wr_be=0 is a no-op.
REQ-022 A read issued at edge N SHALL present data_out and rd_valid=1 after edge N+1 (latency 1); rd_valid=0 otherwise.
REQ-023 data_out SHALL hold its last value when no read completes.
REQ-024 Simultaneous read and write to the same address SHALL return write-first data: enabled bytes from data_in, remaining bytes from the stored word.
REQ-025 Write with wr_addr >= DEPTH SHALL be dropped with req_drop pulse; read with rd_addr >= DEPTH SHALL return 0 with rd_valid=1 and req_drop pulse.
REQ-026 clr_start and wr_en/rd_en in the same IDLE cycle: the write/read SHALL be performed, then CLEAR begins next cycle.

Reset
REQ-027 On reset assertion: data_out=0, rd_valid=0, req_drop=0, pipeline stages cleared, FSM forced to CLEAR with counter 0 (clr_busy=1).
REQ-028 After reset release the block SHALL complete a full DEPTH-cycle clear before accepting requests; reset mid-clear restarts the clear at address 0.

Configuration
REQ-029 Macro RAM_DP_OUT_REG_EN defined: an output register SHALL be added, read latency 2, rd_valid and req_drop for reads delayed equally, bypass rule of REQ-024 unchanged.
REQ-030 Macro RAM_DP_OUT_REG_EN undefined: read latency SHALL be 1 and no output register exists.

Structure
REQ-031 Package ram_dp_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the latency constants (1 and 2).
REQ-032 The FSM and clear counter SHALL be a sub-module ram_dp_clr_ctrl providing the clear address, clear write strobe and busy flag.
REQ-033 Storage array, byte-merge bypass and optional output stage SHALL reside in ram_dp_clr.

Verification
REQ-034 Reset release, WIDTH=32, DEPTH=64 -> clr_busy high exactly 64 cycles; a read of any address afterwards returns 0x00000000.
REQ-035 Write 0xAABBCCDD to addr 5 with be=4'b1111, then be=4'b0010 with data 0x11223344 -> a read of addr 5 returns 0xAABB33DD.
REQ-036 addr 7 holds 0x01020304; same-cycle write 0xFFFFFFFF be=4'b1000 and read of addr 7 -> data_out=0xFF020304 after 1 cycle (2 cycles with RAM_DP_OUT_REG_EN).
REQ-037 clr_start, then wr_en during cycle 3 of the clear -> req_drop pulse, clr_busy stays high 64 cycles, afterwards all words read 0.
REQ-038 DEPTH=48, read addr 50 -> data_out=0, rd_valid=1, req_drop=1; write addr 50 -> array unchanged, req_drop=1.
REQ-039 Reset asserted at clear cycle 20 and released -> clear restarts at address 0 and clr_busy lasts the full DEPTH cycles.
